inst_fetch_buffer: RTL and testbench
====================================

Name: inst_fetch_buffer

Overview:
- Consumer side of the program counter: reads the current PC and drives its enable.
- Issues reads to the synchronous instruction memory and captures the returned words.
- Holds the words in a small first-word-fall-through queue and presents them to decode with a valid/ready handshake.
- Credit-based issue guarantees the queue never overflows; flush discards queued and in-flight fetches on redirect.

Parameters:
- INST_WIDTH, 32, instruction word width.
- ADDR_WIDTH, 10, instruction address width (matches PC width).
- DEPTH, 4, queue entries (power of two, 2..16).
- MEM_LATENCY, 1, cycles from imem_rd to valid imem_rdata (legal 1 or 2).

Ports:
- clk  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-low (0 = reset asserted); deassertion is synchronous to clk externally.
- pc_in  input  ADDR_WIDTH  current PC from the PC counter.
- pc_en  output  1  advance the PC counter; high exactly in issue cycles.
- imem_rd  output  1  instruction memory read strobe.
- imem_addr  output  ADDR_WIDTH  read address; equals pc_in.
- imem_rdata  input  INST_WIDTH  read data, valid MEM_LATENCY cycles after imem_rd.
- flush  input  1  discard all queued and in-flight fetches.
- inst_valid  output  1  queue head valid.
- inst_ready  input  1  decode accepts head.
- inst_out  output  INST_WIDTH  queue head instruction.
- inst_pc  output  ADDR_WIDTH  address of the head instruction.

Behaviour:
- Reset (reset=0, async):
  - Queue empty: count=0, read/write pointers 0.
  - In-flight valid shift register cleared; inst_valid=0.
  - inst_out and inst_pc are 0.
- Issue condition: issue = !flush && (count + inflight < DEPTH), where inflight = number of set bits in the MEM_LATENCY-deep valid pipe.
  - pc_en = imem_rd = issue (combinational).
  - imem_addr = pc_in.
- In-flight pipe:
  - Stage 0 captures {issue, pc_in}; further stages shift each cycle.
  - The final stage valid means imem_rdata is valid this cycle; its word is pushed together with that stage's pc.
- Queue:
  - First-word fall-through: inst_valid = (count != 0); inst_out and inst_pc show the head entry combinationally from the storage array.
  - Pop when inst_valid && inst_ready.
  - Push and pop in the same cycle are both performed; count is unchanged and the pointers advance.
  - Pointers are log2(DEPTH) bits and wrap naturally.
  - count is log2(DEPTH)+1 bits, range 0..DEPTH.
- Full/empty:
  - Credit accounting makes a push while count==DEPTH impossible; the bench asserts this.
  - Pop while empty is ignored.
- Flush (sampled at rising edge):
  - Next cycle: count=0, pointers reset to 0, all in-flight valid bits cleared.
  - No issue in the flush cycle.
  - Memory data returning for squashed fetches is dropped.
  - A pop or push coincident with flush is discarded; flush wins.
  - PC redirection is handled outside this block; the first issue after flush uses the new pc_in.
- Steady state, with decode always ready and MEM_LATENCY=1: one issue per cycle; first inst_valid 2 cycles after reset release (1 memory cycle + 1 queue write).
- Stall: inst_ready=0 lets the queue fill. Issue stops when count+inflight reaches DEPTH; pc_en drops the same cycle, so the PC never runs ahead of the available buffer space.
- Reset asserted mid-operation: state clears immediately; the outputs above take their reset values without waiting for a clock.

Test Plan:
- Reset release, pc counter 0,1,2..., inst_ready=1, MEM_LATENCY=1, memory returns word = 0xA000_0000+addr → inst_valid rises in cycle 2; inst_out/inst_pc sequence 0xA0000000/0, 0xA0000001/1, ...; one instruction per cycle.
- inst_ready=0 from reset, DEPTH=4 → exactly 4 pc_en pulses, then pc_en=0; count=4; raising inst_ready drains pcs 0,1,2,3 in order, with issue resuming the cycle after the first pop.
- Flush asserted with 3 queued and 1 in flight, pc_in then forced to 0x040 → inst_valid=0 the next cycle; the squashed return never appears; the first delivered instruction has inst_pc=0x040.
- MEM_LATENCY=2, inst_ready toggling 1/0 each cycle → in-order delivery; count+inflight never exceeds 4; no overflow assertion fires.
- Wrap check, 20 instructions through DEPTH=4 with random inst_ready → pcs 0..19 delivered exactly once, in order.
- reset driven to 0 mid-stream between clock edges → inst_valid=0 immediately and pc_en=0; after release, fetch restarts cleanly from the current pc_in.

Source files
------------

// File: rtl/inst_fetch_buffer.sv
// inst_fetch_buffer: fetch front end between the PC counter, a synchronous
// instruction memory and decode. Reads are issued only when a queue slot is
// guaranteed for the returning word, so the first-word-fall-through queue
// can never overflow. flush squashes every queued and in-flight fetch.
module inst_fetch_buffer #(
  parameter int INST_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 10,
  parameter int DEPTH       = 4,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  output logic                  pc_en,
  output logic                  imem_rd,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [INST_WIDTH-1:0] imem_rdata,
  input  logic                  flush,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [INST_WIDTH-1:0] inst_out,
  output logic [ADDR_WIDTH-1:0] inst_pc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [MEM_LATENCY-1:0] pipe_valid;
  logic [ADDR_WIDTH-1:0]  pipe_pc [MEM_LATENCY];

  logic [INST_WIDTH-1:0]  store_word [DEPTH];
  logic [ADDR_WIDTH-1:0]  store_pc   [DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       count;

  logic [CNT_W-1:0]       inflight;
  logic [CNT_W:0]         occupancy;
  logic                   issue;
  logic                   push;
  logic                   pop;

  // Credit check: queued words plus outstanding reads must leave room for one more.
  // Reset is folded in so the PC is never advanced while the block is held in reset.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < MEM_LATENCY; i++) begin
      inflight = inflight + CNT_W'(pipe_valid[i]);
    end
    occupancy = {1'b0, count} + {1'b0, inflight};
    issue     = reset && !flush && (occupancy < (CNT_W+1)'(DEPTH));
  end

  assign pc_en      = issue;
  assign imem_rd    = issue;
  assign imem_addr  = pc_in;

  assign push       = pipe_valid[MEM_LATENCY-1] && !flush;
  assign inst_valid = (count != '0);
  assign pop        = inst_valid && inst_ready && !flush;

  // Head entry falls through combinationally; forced to zero while the queue is empty.
  assign inst_out   = inst_valid ? store_word[rd_ptr] : '0;
  assign inst_pc    = inst_valid ? store_pc[rd_ptr]   : '0;

  // In-flight pipe tracks which outstanding reads are live and their addresses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_valid <= '0;
      for (int i = 0; i < MEM_LATENCY; i++) begin
        pipe_pc[i] <= '0;
      end
    end else if (flush) begin
      pipe_valid <= '0;
    end else begin
      for (int i = 1; i < MEM_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_pc[i]    <= pipe_pc[i-1];
      end
      pipe_valid[0] <= issue;
      pipe_pc[0]    <= pc_in;
    end
  end

  // Queue storage captures the returning word with the address that fetched it.
  always_ff @(posedge clk) begin
    if (push) begin
      store_word[wr_ptr] <= imem_rdata;
      store_pc[wr_ptr]   <= pipe_pc[MEM_LATENCY-1];
    end
  end

  // Pointers and occupancy; flush empties the queue and rewinds both pointers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// tb_inst_fetch_buffer: drives one buffer with a one-cycle memory and one with
// a two-cycle memory from shared decode/flush/reset stimulus. Each instance has
// its own PC counter, memory model and scoreboard of expected deliveries.
module tb_inst_fetch_buffer;

  localparam int INST_WIDTH = 32;
  localparam int ADDR_WIDTH = 10;
  localparam int DEPTH      = 4;
  localparam int NUM_DUTS   = 2;
  localparam int NUM_VECS   = 17;

  typedef struct {
    logic [INST_WIDTH-1:0] word;
    logic [ADDR_WIDTH-1:0] pc;
  } fetch_t;

  typedef struct {
    logic                  ready;
    logic                  flush;
    logic                  exp_pc_en;
    logic                  exp_valid;
    logic [ADDR_WIDTH-1:0] exp_pc;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  logic inst_ready;

  logic [NUM_DUTS-1:0]   pc_en_w;
  logic [NUM_DUTS-1:0]   imem_rd_w;
  logic [NUM_DUTS-1:0]   inst_valid_w;
  logic [ADDR_WIDTH-1:0] addr_w    [NUM_DUTS];
  logic [ADDR_WIDTH-1:0] inst_pc_w [NUM_DUTS];
  logic [INST_WIDTH-1:0] inst_out_w[NUM_DUTS];

  int checks   = 0;
  int failures = 0;

  vec_t vecs [NUM_VECS];

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  function automatic logic [INST_WIDTH-1:0] mem_word(input logic [ADDR_WIDTH-1:0] a);
    return 32'hA000_0000 + 32'(a);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic ready, input logic fl);
    inst_ready = ready;
    flush      = fl;
  endtask

  for (genvar g = 0; g < NUM_DUTS; g++) begin : gen_lat
    localparam int LAT = g + 1;

    logic [ADDR_WIDTH-1:0] pc_reg = '0;
    logic [INST_WIDTH-1:0] rd_pipe [LAT];
    logic [INST_WIDTH-1:0] imem_rdata;

    fetch_t                exp_q [$];
    logic                  mv    [LAT];
    logic [ADDR_WIDTH-1:0] mpc   [LAT];

    // PC counter: redirected to 0x040 by flush, otherwise advanced by pc_en.
    always @(posedge clk) begin
      if (flush) pc_reg <= 10'h040;
      else if (pc_en_w[g]) pc_reg <= pc_reg + 1'b1;
    end

    // Synchronous memory; non-read cycles return junk so stray pushes are visible.
    always @(posedge clk) begin
      rd_pipe[0] <= imem_rd_w[g] ? mem_word(addr_w[g]) : 32'hDEAD_BEEF;
      for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    assign imem_rdata = rd_pipe[LAT-1];

    inst_fetch_buffer #(
      .INST_WIDTH (INST_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (DEPTH),
      .MEM_LATENCY(LAT)
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .pc_in     (pc_reg),
      .pc_en     (pc_en_w[g]),
      .imem_rd   (imem_rd_w[g]),
      .imem_addr (addr_w[g]),
      .imem_rdata(imem_rdata),
      .flush     (flush),
      .inst_valid(inst_valid_w[g]),
      .inst_ready(inst_ready),
      .inst_out  (inst_out_w[g]),
      .inst_pc   (inst_pc_w[g])
    );

    // Scoreboard: compare outputs mid-cycle, then advance the model to the next edge.
    always @(negedge clk) begin
      int   inflight;
      logic exp_issue;
      logic exp_pop;
      logic exp_push;
      fetch_t f;
      if (!reset) begin
        exp_q.delete();
        for (int i = 0; i < LAT; i++) mv[i] = 1'b0;
        checkOutput($sformatf("lat%0d reset pc_en", LAT), 32'(pc_en_w[g]), 32'd0);
        checkOutput($sformatf("lat%0d reset inst_valid", LAT), 32'(inst_valid_w[g]), 32'd0);
        checkOutput($sformatf("lat%0d reset inst_out", LAT), inst_out_w[g], 32'd0);
        checkOutput($sformatf("lat%0d reset inst_pc", LAT), 32'(inst_pc_w[g]), 32'd0);
      end else begin
        inflight = 0;
        for (int i = 0; i < LAT; i++) if (mv[i]) inflight++;
        exp_issue = !flush && ((exp_q.size() + inflight) < DEPTH);
        checkOutput($sformatf("lat%0d pc_en", LAT), 32'(pc_en_w[g]), 32'(exp_issue));
        checkOutput($sformatf("lat%0d imem_rd", LAT), 32'(imem_rd_w[g]), 32'(exp_issue));
        if (exp_issue)
          checkOutput($sformatf("lat%0d imem_addr", LAT), 32'(addr_w[g]), 32'(pc_reg));
        checkOutput($sformatf("lat%0d inst_valid", LAT), 32'(inst_valid_w[g]),
                    32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
          checkOutput($sformatf("lat%0d inst_pc", LAT), 32'(inst_pc_w[g]), 32'(exp_q[0].pc));
          checkOutput($sformatf("lat%0d inst_out", LAT), inst_out_w[g], exp_q[0].word);
        end
        checks++;
        if (u_dut.pipe_valid[LAT-1] && !flush && (u_dut.count == DEPTH) &&
            !(inst_valid_w[g] && inst_ready)) begin
          failures++;
          $display("[TB] FAIL lat%0d overflow push_at_count=%0d allowed_max=%0d t=%0t",
                   LAT, u_dut.count, DEPTH - 1, $time);
        end
        exp_pop  = (exp_q.size() != 0) && inst_ready;
        exp_push = mv[LAT-1];
        if (flush) begin
          exp_q.delete();
          for (int i = 0; i < LAT; i++) mv[i] = 1'b0;
        end else begin
          if (exp_pop) void'(exp_q.pop_front());
          if (exp_push) begin
            f.pc   = mpc[LAT-1];
            f.word = mem_word(mpc[LAT-1]);
            exp_q.push_back(f);
          end
          for (int i = LAT - 1; i > 0; i--) begin
            mv[i]  = mv[i-1];
            mpc[i] = mpc[i-1];
          end
          mv[0]  = exp_issue;
          mpc[0] = pc_reg;
        end
      end
    end
  end

  // Directed table for the one-cycle memory, then free-running sequences.
  initial begin
    //         ready flush pc_en valid pc
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 10'h000};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 10'h000};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 10'h000};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 10'h001};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 10'h002};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 10'h002};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 10'h002};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 10'h002};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 10'h002};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 10'h003};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 10'h004};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 10'h005};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 10'h005};
    vecs[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 10'h000};
    vecs[14] = '{1'b1, 1'b0, 1'b1, 1'b0, 10'h000};
    vecs[15] = '{1'b1, 1'b0, 1'b1, 1'b1, 10'h040};
    vecs[16] = '{1'b1, 1'b0, 1'b1, 1'b1, 10'h041};

    reset = 1'b0;
    applyStimulus(1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;

    for (int i = 0; i < NUM_VECS; i++) begin
      applyStimulus(vecs[i].ready, vecs[i].flush);
      if (i == 0) reset = 1'b1;
      @(negedge clk);
      checkOutput($sformatf("vec%0d pc_en", i), 32'(pc_en_w[0]), 32'(vecs[i].exp_pc_en));
      checkOutput($sformatf("vec%0d inst_valid", i), 32'(inst_valid_w[0]), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid)
        checkOutput($sformatf("vec%0d inst_pc", i), 32'(inst_pc_w[0]), 32'(vecs[i].exp_pc));
      @(posedge clk);
      #1;
    end

    for (int c = 0; c < 40; c++) begin
      applyStimulus(c[0] == 1'b0, 1'b0);
      @(posedge clk);
      #1;
    end

    for (int c = 0; c < 80; c++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'b0);
      @(posedge clk);
      #1;
    end

    applyStimulus(1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    for (int g = 0; g < NUM_DUTS; g++) begin
      checkOutput($sformatf("async reset dut%0d inst_valid", g), 32'(inst_valid_w[g]), 32'd0);
      checkOutput($sformatf("async reset dut%0d pc_en", g), 32'(pc_en_w[g]), 32'd0);
      checkOutput($sformatf("async reset dut%0d inst_out", g), inst_out_w[g], 32'd0);
      checkOutput($sformatf("async reset dut%0d inst_pc", g), 32'(inst_pc_w[g]), 32'd0);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    for (int c = 0; c < 40; c++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'b0);
      @(posedge clk);
      #1;
    end

    applyStimulus(1'b1, 1'b0);
    repeat (20) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
